// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   mode_t          3-bit operation selector carried with every bundle
//   MODE_*          legal operation encodings; 101..111 are illegal
//   is_legal_mode() 1 when the encoding names a real operation
package bshift_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_SLL = 3'b000;
   localparam mode_t MODE_SRL = 3'b001;
   localparam mode_t MODE_SRA = 3'b010;
   localparam mode_t MODE_ROL = 3'b011;
   localparam mode_t MODE_ROR = 3'b100;

   function automatic logic is_legal_mode(input mode_t m);
      return (m <= MODE_ROR);
   endfunction

endpackage

// File: rtl/bshift_stage.sv
// One register stage of the pipelined barrel shifter.
// Holds NUM_LEVELS shift/rotate levels starting at level FIRST_LEVEL
// (level k moves the data by 2^k when shamt[k]=1), followed by the stage
// register for the whole bundle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   up_*              bundle from the previous stage (or the issue port)
//   down_advance      1 when the following stage (or consumer) takes data
//   advance           1 when this stage loads a new bundle this cycle
//   valid, data,      registered bundle: valid bit, partially shifted data,
//   shamt, mode,      shift amount and mode still needed downstream,
//   cout, err         carry-out and illegal-mode flag computed at issue
//   zero              1 when the registered data is all zeros
module bshift_stage
   import bshift_pkg::*;
#(
   parameter int N           = 32,
   parameter int FIRST_LEVEL = 0,
   parameter int NUM_LEVELS  = 1,
   parameter int LOG2N       = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   input  logic [N-1:0]     up_data,
   input  logic [LOG2N-1:0] up_shamt,
   input  logic [2:0]       up_mode,
   input  logic             up_cout,
   input  logic             up_err,
   input  logic             down_advance,
   output logic             advance,
   output logic             valid,
   output logic [N-1:0]     data,
   output logic [LOG2N-1:0] shamt,
   output logic [2:0]       mode,
   output logic             cout,
   output logic             err,
   output logic             zero
);

   // Illegal modes fall through unchanged, which gives y = a at the output.
   function automatic logic [N-1:0] shift_level(input logic [N-1:0] d,
                                                input logic [2:0]   m,
                                                input int           amt);
      case (m)
         MODE_SLL: return d << amt;
         MODE_SRL: return d >> amt;
         MODE_SRA: return $unsigned($signed(d) >>> amt);
         MODE_ROL: return (d << amt) | (d >> (N - amt));
         MODE_ROR: return (d >> amt) | (d << (N - amt));
         default:  return d;
      endcase
   endfunction

   logic [N-1:0] net;

   // Levels compose in any order; SRA stays correct because each level
   // refills from the current MSB, which is still the original sign bit.
   always_comb begin
      logic [LOG2N-1:0] sel;
      net = up_data;
      sel = up_shamt >> FIRST_LEVEL;
      for (int g = 0; g < NUM_LEVELS; g++) begin
         if (sel[0]) net = shift_level(net, up_mode, 1 << (FIRST_LEVEL + g));
         sel = sel >> 1;
      end
   end

   assign advance = !valid || down_advance;

   // ---- stage register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         shamt <= '0;
         mode  <= '0;
         cout  <= 1'b0;
         err   <= 1'b0;
         zero  <= 1'b0;
      end else if (advance) begin
         valid <= up_valid;
         data  <= net;
         shamt <= up_shamt;
         mode  <= up_mode;
         cout  <= up_cout;
         err   <= up_err;
         zero  <= (net == '0);
      end
   end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with SLL/SRL/SRA/ROL/ROR, carry-out, zero and
// illegal-mode flags, and valid/ready handshakes with full backpressure.
// Latency is PIPE_STAGES cycles; throughput one bundle per cycle.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_ready    issue handshake
//   a, shamt, mode        operand, shift amount 0..N-1, operation
//   out_valid, out_ready  result handshake
//   y, cout, zero, err    result, last bit moved out, y==0, illegal mode
module pipelined_barrel_shifter
   import bshift_pkg::*;
#(
   parameter int N           = 32,
   parameter int PIPE_STAGES = 2,
   parameter int LOG2N       = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [LOG2N-1:0] shamt,
   input  logic [2:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     y,
   output logic             cout,
   output logic             zero,
   output logic             err
);

   localparam int LEVELS_PER_STAGE = (LOG2N + PIPE_STAGES - 1) / PIPE_STAGES;

   // Carry-out depends only on the operand and the full shift amount, so it
   // is resolved once at issue. Rotates move out the same bit the matching
   // shift would (y[0] = a[N-s] for ROL, y[N-1] = a[s-1] for ROR).
   function automatic logic calc_cout(input logic [N-1:0]     d,
                                      input logic [LOG2N-1:0] s,
                                      input logic [2:0]       m);
      logic [LOG2N-1:0] left_idx;
      logic [LOG2N-1:0] right_idx;
      left_idx  = '0 - s;
      right_idx = s - LOG2N'(1);
      if (s == '0) return 1'b0;
      case (m)
         MODE_SLL, MODE_ROL:           return d[left_idx];
         MODE_SRL, MODE_SRA, MODE_ROR: return d[right_idx];
         default:                      return 1'b0;
      endcase
   endfunction

   logic issue_cout;
   logic issue_err;

   assign issue_cout = calc_cout(a, shamt, mode);
   assign issue_err  = !is_legal_mode(mode);

   logic [PIPE_STAGES-1:0] vld_p;
   logic [PIPE_STAGES-1:0] cout_p;
   logic [PIPE_STAGES-1:0] err_p;
   logic [PIPE_STAGES-1:0] zero_p;
   logic [PIPE_STAGES-1:0] adv_p;
   logic [N-1:0]           data_p  [PIPE_STAGES];
   logic [LOG2N-1:0]       shamt_p [PIPE_STAGES];
   logic [2:0]             mode_p  [PIPE_STAGES];

   for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
      // Ceil-sized groups of levels; the last stage gets what is left.
      localparam int FIRST = (i * LEVELS_PER_STAGE < LOG2N) ? i * LEVELS_PER_STAGE : LOG2N;
      localparam int NUM   = (LOG2N - FIRST < LEVELS_PER_STAGE) ? LOG2N - FIRST : LEVELS_PER_STAGE;

      logic             up_valid;
      logic [N-1:0]     up_data;
      logic [LOG2N-1:0] up_shamt;
      logic [2:0]       up_mode;
      logic             up_cout;
      logic             up_err;
      logic             down_advance;

      if (i == 0) begin : g_head
         assign up_valid = in_valid;
         assign up_data  = a;
         assign up_shamt = shamt;
         assign up_mode  = mode;
         assign up_cout  = issue_cout;
         assign up_err   = issue_err;
      end else begin : g_body
         assign up_valid = vld_p[i-1];
         assign up_data  = data_p[i-1];
         assign up_shamt = shamt_p[i-1];
         assign up_mode  = mode_p[i-1];
         assign up_cout  = cout_p[i-1];
         assign up_err   = err_p[i-1];
      end

      // The downstream chain advances when the consumer is ready or any
      // later stage has a bubble; written flat so there is no combinational
      // ripple from stage to stage.
      if (i == PIPE_STAGES - 1) begin : g_tail
         assign down_advance = out_ready;
      end else begin : g_mid
         assign down_advance = out_ready || !(&vld_p[PIPE_STAGES-1:i+1]);
      end

      bshift_stage #(
         .N           (N),
         .FIRST_LEVEL (FIRST),
         .NUM_LEVELS  (NUM),
         .LOG2N       (LOG2N)
      ) u_stage (
         .clk          (clk),
         .rst_n        (rst_n),
         .up_valid     (up_valid),
         .up_data      (up_data),
         .up_shamt     (up_shamt),
         .up_mode      (up_mode),
         .up_cout      (up_cout),
         .up_err       (up_err),
         .down_advance (down_advance),
         .advance      (adv_p[i]),
         .valid        (vld_p[i]),
         .data         (data_p[i]),
         .shamt        (shamt_p[i]),
         .mode         (mode_p[i]),
         .cout         (cout_p[i]),
         .err          (err_p[i]),
         .zero         (zero_p[i])
      );
   end

   assign in_ready  = adv_p[0];
   assign out_valid = vld_p[PIPE_STAGES-1];
   assign y         = data_p[PIPE_STAGES-1];
   assign cout      = cout_p[PIPE_STAGES-1];
   assign err       = err_p[PIPE_STAGES-1];
   assign zero      = zero_p[PIPE_STAGES-1];

   // Intermediate zero flags, inner advances and the final stage's
   // shamt/mode copies have no consumer.
   logic unused_bits;
   assign unused_bits = ^{adv_p, zero_p, shamt_p[PIPE_STAGES-1], mode_p[PIPE_STAGES-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

   typedef struct packed {
      logic [31:0] y;
      logic        cout;
      logic        zero;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic [31:0] a;
      logic [4:0]  s;
      logic [2:0]  m;
      logic [31:0] y;
      logic        cout;
   } vec_t;

   localparam int LAT [3] = '{1, 2, 5};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0;
   logic [4:0]  shamt = '0;
   logic [2:0]  mode = '0;

   logic        rdy [3];
   logic        ov  [3];
   logic [31:0] yv  [3];
   logic        cv  [3];
   logic        zv  [3];
   logic        ev  [3];

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q [$];

   always #5 clk = ~clk;

   pipelined_barrel_shifter #(.N(32), .PIPE_STAGES(1)) u_p1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .a(a), .shamt(shamt), .mode(mode), .out_valid(ov[0]), .out_ready(out_ready),
      .y(yv[0]), .cout(cv[0]), .zero(zv[0]), .err(ev[0]));

   pipelined_barrel_shifter #(.N(32), .PIPE_STAGES(2)) u_p2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .a(a), .shamt(shamt), .mode(mode), .out_valid(ov[1]), .out_ready(out_ready),
      .y(yv[1]), .cout(cv[1]), .zero(zv[1]), .err(ev[1]));

   pipelined_barrel_shifter #(.N(32), .PIPE_STAGES(5)) u_p5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
      .a(a), .shamt(shamt), .mode(mode), .out_valid(ov[2]), .out_ready(out_ready),
      .y(yv[2]), .cout(cv[2]), .zero(zv[2]), .err(ev[2]));

   // Independent reference: shifts on a widened word so the last bit moved
   // out lands in the extra position.
   function automatic exp_t model(input logic [31:0] d, input logic [4:0] s, input logic [2:0] m);
      exp_t        e;
      logic [32:0] t;
      logic [63:0] w;
      e.err  = 1'b0;
      e.cout = 1'b0;
      case (m)
         3'd0: begin t = {1'b0, d} << s; e.y = t[31:0]; e.cout = t[32]; end
         3'd1: begin t = {d, 1'b0} >> s; e.y = t[32:1]; e.cout = t[0]; end
         3'd2: begin t = $unsigned($signed({d, 1'b0}) >>> s); e.y = t[32:1]; e.cout = t[0]; end
         3'd3: begin w = {d, d} << s; e.y = w[63:32]; e.cout = (s != 0) && e.y[0]; end
         3'd4: begin w = {d, d} >> s; e.y = w[31:0]; e.cout = (s != 0) && e.y[31]; end
         default: begin e.y = d; e.err = 1'b1; end
      endcase
      e.zero = (e.y == 32'd0);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      for (bit [1:0] k = 0; k < 2'd3; k++) begin
         checks++;
         if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, ov[k]); end
         checks++;
         if ({yv[k], cv[k], zv[k], ev[k]} !== 35'd0)
            begin errors++; $display("FAIL reset_outputs[%0d]: got y=%h c=%b z=%b e=%b expected all 0", k, yv[k], cv[k], zv[k], ev[k]); end
      end
      rst_n = 1'b1;
      #1;
      for (bit [1:0] k = 0; k < 2'd3; k++) begin
         checks++;
         if (rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, rdy[k]); end
      end
      tick();
   endtask

   task automatic test_vectors();
      vec_t vt [8];
      logic [2:0] seen;
      exp_t e;
      vt[0] = '{32'h12345678, 5'd4,  3'd0, 32'h23456780, 1'b1};
      vt[1] = '{32'h12345678, 5'd12, 3'd1, 32'h00012345, 1'b0};
      vt[2] = '{32'hF2345678, 5'd4,  3'd2, 32'hFF234567, 1'b1};
      vt[3] = '{32'hF2345678, 5'd1,  3'd2, 32'hF91A2B3C, 1'b0};
      vt[4] = '{32'h80000001, 5'd1,  3'd3, 32'h00000003, 1'b1};
      vt[5] = '{32'h00000001, 5'd1,  3'd4, 32'h80000000, 1'b1};
      vt[6] = '{32'h00000001, 5'd31, 3'd0, 32'h80000000, 1'b0};
      vt[7] = '{32'h00000001, 5'd1,  3'd1, 32'h00000000, 1'b1};
      out_ready = 1'b1;
      for (int v = 0; v < 8; v++) begin
         a = vt[v].a; shamt = vt[v].s; mode = vt[v].m; in_valid = 1'b1;
         sb_q.push_back('{vt[v].y, vt[v].cout, (vt[v].y == 32'd0), 1'b0});
         tick();
         in_valid = 1'b0;
         seen = 3'b000;
         e = sb_q[0];
         for (int c = 1; c <= 8 && seen != 3'b111; c++) begin
            for (bit [1:0] k = 0; k < 2'd3; k++) begin
               if (ov[k] && !seen[k]) begin
                  seen[k] = 1'b1;
                  checks++;
                  if (c != LAT[k]) begin errors++; $display("FAIL vec%0d_latency[%0d]: got %0d expected %0d", v, k, c, LAT[k]); end
                  checks++;
                  if (yv[k] !== e.y) begin errors++; $display("FAIL vec%0d_y[%0d]: got %h expected %h", v, k, yv[k], e.y); end
                  checks++;
                  if (cv[k] !== e.cout) begin errors++; $display("FAIL vec%0d_cout[%0d]: got %b expected %b", v, k, cv[k], e.cout); end
                  checks++;
                  if (zv[k] !== e.zero || ev[k] !== e.err)
                     begin errors++; $display("FAIL vec%0d_flags[%0d]: got z=%b e=%b expected z=%b e=%b", v, k, zv[k], ev[k], e.zero, e.err); end
               end
            end
            if (seen != 3'b111) tick();
         end
         for (bit [1:0] k = 0; k < 2'd3; k++) begin
            if (!seen[k]) begin checks++; errors++; $display("FAIL vec%0d_timeout[%0d]: got no out_valid expected one", v, k); end
         end
         void'(sb_q.pop_front());
         tick();
      end
   endtask

   task automatic test_illegal();
      int   got = 0;
      exp_t e;
      out_ready = 1'b1;
      sb_q.push_back('{32'hDEADBEEF, 1'b0, 1'b0, 1'b1});
      sb_q.push_back('{32'h0000000F, 1'b0, 1'b0, 1'b0});
      a = 32'hDEADBEEF; shamt = 5'd9; mode = 3'b111; in_valid = 1'b1;
      tick();
      a = 32'h000000F0; shamt = 5'd4; mode = 3'd1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 10 && got < 2; c++) begin
         if (ov[1]) begin
            e = sb_q.pop_front();
            checks++;
            if ({yv[1], cv[1], zv[1], ev[1]} !== {e.y, e.cout, e.zero, e.err})
               begin errors++; $display("FAIL illegal_%0d: got y=%h c=%b z=%b e=%b expected y=%h c=%b z=%b e=%b",
                        got, yv[1], cv[1], zv[1], ev[1], e.y, e.cout, e.zero, e.err); end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 2) begin errors++; $display("FAIL illegal_count: got %0d results expected 2", got); end
      sb_q.delete();
      repeat (6) tick();
   endtask

   task automatic test_back_to_back();
      int   sent = 0;
      int   got = 0;
      exp_t e;
      out_ready = 1'b1;
      for (int c = 0; c < 60 && got < 12; c++) begin
         if (sent < 12) begin
            a = $urandom; shamt = 5'($urandom_range(0, 31)); mode = 3'($urandom_range(0, 7));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid) begin
            checks++;
            if (rdy[1] !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1 at cycle %0d", rdy[1], c); end
         end
         if (in_valid && rdy[1]) begin sb_q.push_back(model(a, shamt, mode)); sent++; end
         if (ov[1]) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++; $display("FAIL b2b_extra: got unexpected result y=%h expected none", yv[1]);
            end else begin
               e = sb_q.pop_front();
               if ({yv[1], cv[1], zv[1], ev[1]} !== {e.y, e.cout, e.zero, e.err})
                  begin errors++; $display("FAIL b2b_result%0d: got y=%h c=%b z=%b e=%b expected y=%h c=%b z=%b e=%b",
                           got, yv[1], cv[1], zv[1], ev[1], e.y, e.cout, e.zero, e.err); end
            end
            got++;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (got != 12) begin errors++; $display("FAIL b2b_count: got %0d results expected 12", got); end
      sb_q.delete();
      repeat (6) tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] ba [4];
      logic [4:0]  bs [4];
      logic [2:0]  bm [4];
      logic [31:0] hold_y = '0;
      bit          have_hold = 1'b0;
      int          sent = 0;
      int          got = 0;
      int          first_out = -1;
      int          last_out = -1;
      exp_t        e;
      ba = '{32'h12345678, 32'hF0000001, 32'h0000FFFF, 32'h80000000};
      bs = '{5'd8, 5'd3, 5'd16, 5'd31};
      bm = '{3'd0, 3'd2, 3'd3, 3'd1};
      for (int t = 0; t < 30 && got < 4; t++) begin
         out_ready = (t >= 6);
         if (sent < 4) begin a = ba[sent]; shamt = bs[sent]; mode = bm[sent]; in_valid = 1'b1; end
         else in_valid = 1'b0;
         #1;
         if (t == 5) begin
            checks++;
            if (sent != 2 || rdy[1] !== 1'b0)
               begin errors++; $display("FAIL bp_stall: got accepts=%0d in_ready=%b expected accepts=2 in_ready=0", sent, rdy[1]); end
         end
         if (ov[1] && !out_ready) begin
            if (have_hold) begin
               checks++;
               if (yv[1] !== hold_y) begin errors++; $display("FAIL bp_hold_y: got %h expected %h", yv[1], hold_y); end
            end
            hold_y = yv[1]; have_hold = 1'b1;
         end
         if (in_valid && rdy[1]) begin sb_q.push_back(model(a, shamt, mode)); sent++; end
         if (ov[1] && out_ready) begin
            checks++;
            e = sb_q.pop_front();
            if ({yv[1], cv[1], zv[1], ev[1]} !== {e.y, e.cout, e.zero, e.err})
               begin errors++; $display("FAIL bp_result%0d: got y=%h c=%b z=%b e=%b expected y=%h c=%b z=%b e=%b",
                        got, yv[1], cv[1], zv[1], ev[1], e.y, e.cout, e.zero, e.err); end
            if (first_out < 0) first_out = t;
            last_out = t;
            got++;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (got != 4 || last_out - first_out != 3)
         begin errors++; $display("FAIL bp_drain: got %0d results over %0d cycles expected 4 over 3", got, last_out - first_out); end
      sb_q.delete();
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      a = 32'hCAFEF00D; shamt = 5'd3; mode = 3'd0; in_valid = 1'b1;
      tick();
      a = 32'h0BADBEEF; mode = 3'd4;
      tick();
      in_valid = 1'b0;
      checks++;
      if (ov[1] !== 1'b1) begin errors++; $display("FAIL midreset_inflight: got out_valid %b expected 1", ov[1]); end
      rst_n = 1'b0;
      tick();
      for (bit [1:0] k = 0; k < 2'd3; k++) begin
         checks++;
         if (ov[k] !== 1'b0) begin errors++; $display("FAIL midreset_clear[%0d]: got %b expected 0", k, ov[k]); end
      end
      rst_n = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ov[2] !== 1'b0)
            begin errors++; $display("FAIL midreset_emit: got out_valid %b%b%b expected 000 at cycle %0d", ov[2], ov[1], ov[0], c); end
         tick();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_vectors();
      test_illegal();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the team's combinational barrel shifter. Adds rotate modes, carry-out and zero flags, and a configurable number of pipeline registers. Uses a valid/ready handshake with full backpressure. Sits in the datapath between operand issue and the writeback/ALU result mux.

Parameters:
N, 32, data width in bits; N must be a power of two and at least 4.
PIPE_STAGES, 2, number of register stages; legal range 1..$clog2(N).
LOG2N, $clog2(N), derived shift-amount width; not overridden by users.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  synchronous reset, active-low, sampled on rising clk.
in_valid  in  1  operand bundle valid.
in_ready  out  1  block can accept a bundle this cycle.
a  in  N  operand.
shamt  in  LOG2N  shift amount, 0..N-1.
mode  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101..111 illegal.
out_valid  out  1  result bundle valid.
out_ready  in  1  consumer accepts the result.
y  out  N  shifted or rotated result.
cout  out  1  last bit shifted or rotated out.
zero  out  1  1 when y == 0.
err  out  1  1 when the transaction carried an illegal mode.

Behaviour:
- Reset, when rst_n=0 at an edge: every stage valid bit clears to 0. Also at reset: out_valid=0, y=0, cout=0, zero=0, err=0. in_ready=1 on the first cycle after reset deasserts.
- Reset mid-operation: all in-flight transactions are discarded. Nothing is emitted afterwards.
- Transfer rules:
  - An input transfer happens when in_valid and in_ready are both high at an edge.
  - An output transfer happens when out_valid and out_ready are both high at an edge.
- Shift network:
  - LOG2N levels; level k shifts or rotates by 2^k when shamt[k]=1.
  - Levels are split across PIPE_STAGES register stages, ceil(LOG2N/PIPE_STAGES) levels per stage, with any remainder going to the last stage.
  - The sub-module holds the levels for one stage.
- Latency is exactly PIPE_STAGES cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Backpressure:
  - Each stage advances when it is empty or its downstream stage advances.
  - in_ready = !stage0_valid || stage0_advances.
  - When out_valid=1 and out_ready=0, y, cout, zero and err hold stable.
  - No bundle is dropped, duplicated or reordered.
- Mode semantics, with s = shamt:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with a[N-1].
  - ROL and ROR: bits wrap around.
- cout (s=0 gives cout=0 in all modes):
  - SLL: a[N-s].
  - SRL and SRA: a[s-1].
  - ROL: y[0].
  - ROR: y[N-1].
  - cout is computed in stage 0 and travels down the pipeline with the data.
- zero is computed on the final-stage result and registered together with y.
- Illegal mode: y=a, cout=0, err=1; the transaction still follows the normal latency and handshake.
- Simultaneous accept and emit in the same cycle is legal. A full pipeline with out_ready=1 sustains in_ready=1.
- Outputs are all registered. y is not cleared when out_valid drops; it is don't-care while out_valid=0.

Decomposition:
- Shared package bshift_pkg holds:
  - the mode_t 3-bit typedef;
  - constants MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR;
  - function is_legal_mode().
- One sub-module, bshift_stage, parametrised by N, FIRST_LEVEL and NUM_LEVELS:
  - combinational levels plus a valid/data register with the advance logic;
  - instantiated PIPE_STAGES times in a generate loop.

Test Plan:
All scenarios use N=32 and PIPE_STAGES=2 unless stated.
1. SLL a=12345678 s=4 -> y=23456780, cout=1, zero=0; out_valid exactly 2 cycles after accept. SRL a=12345678 s=12 -> y=00012345, cout=0.
2. SRA a=F2345678 s=4 -> y=FF234567, cout=1. SRA a=F2345678 s=1 -> y=F91A2B3C, cout=0.
3. ROL a=80000001 s=1 -> y=00000003, cout=1. ROR a=00000001 s=1 -> y=80000000, cout=1. SLL a=00000001 s=31 -> y=80000000, cout=0. SRL a=00000001 s=1 -> y=0, zero=1, cout=1.
4. Backpressure: issue 4 back-to-back bundles with out_ready=0 for 6 cycles.
   - in_ready drops after 2 accepts.
   - y stays stable while stalled.
   - After out_ready=1, all 4 results emerge in order, one per cycle, with none lost.
5. Illegal mode=111, a=DEADBEEF -> y=DEADBEEF, err=1, cout=0. The next legal transaction has err=0.
6. Reset and parameter sweep:
   - Assert rst_n=0 with 2 bundles in flight: out_valid=0 on the next edge and nothing emerges afterwards.
   - Repeat scenarios 1-3 with PIPE_STAGES=1 and PIPE_STAGES=5: latency equals PIPE_STAGES and results are identical.
